// File: rtl/interval_sched_pkg.sv
// Shared types and helpers for the interval scheduler.
//   state_t  : scheduler phase (IDLE, RUN, DONE)
//   pick_t   : round-robin result (valid flag + winner index)
//   rr_pick  : round-robin search upward from last+1, modulo n
package interval_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 32;
  localparam int MAX_NREQ = 16;

  typedef logic [3:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  // Visits last+1, last+2, ... (mod n) and returns the first requester found.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req_vec,
                                    input idx_t                 last,
                                    input int                   n);
    pick_t p;
    idx_t  cand;
    p = '0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      cand = idx_t'((int'(last) + i) % n);
      if (i <= n && !p.valid && req_vec[cand]) begin
        p.valid = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/interval_scheduler_if.sv
// Requester-side bundle of the interval scheduler.
//   req      : per-requester request level
//   duration : packed window lengths, requester i at [i*CW +: CW]
//   grant    : one-hot owner of the counter (or zero)
//   done     : one-cycle completion pulse per requester
//   busy     : scheduler not idle
//   count    : current interval count
interface interval_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] duration;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;

  modport master (output req, duration, input grant, done, busy, count);
  modport slave  (input req, duration, output grant, done, busy, count);
endinterface

// File: rtl/interval_counter.sv
// CW-bit up counter shared by all requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : increment this cycle
//   clr        : synchronous clear, takes priority over en
//   count      : current value
module interval_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so the flop samples pre-edge values like every other flop.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin scheduler sharing one interval counter between NREQ requesters.
// A winner gets the counter for exactly its latched duration, then receives a
// one-cycle done pulse. Dropping req during the window cancels it silently.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : requester bundle (req, duration in; grant, done, busy, count out)
module interval_scheduler
  import interval_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input logic                 clk,
  input logic                 reset,
  interval_scheduler_if.slave bus
);

  state_t        state_q, state_d;
  idx_t          win_q, win_d;
  idx_t          last_q, last_d;
  logic [CW-1:0] dur_q, dur_d;

  logic [MAX_NREQ-1:0] req_ext;
  pick_t               pick;
  logic [CW-1:0]       dur_sel;
  logic [NREQ-1:0]     win_oh;
  logic                req_w;
  logic [CW-1:0]       cnt;
  logic                cnt_en, cnt_clr;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = bus.req;
    pick                = rr_pick(req_ext, last_q, NREQ);
  end

  // Duration of the candidate winner; only meaningful while pick.valid.
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick.idx == idx_t'(i)) dur_sel = bus.duration[i*CW +: CW];
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == idx_t'(i)) win_oh[i] = 1'b1;
    end
  end

  // Only the current winner's request matters once the window is running.
  assign req_w = |(bus.req & win_oh);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    dur_d   = dur_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick.valid) begin
          win_d   = pick.idx;
          last_d  = pick.idx;
          dur_d   = dur_sel;
          state_d = (dur_sel != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Cancel is checked first so it wins over a coincident final count.
        if (!req_w)                        state_d = S_IDLE;
        else if (cnt == dur_q - CW'(1))    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      last_q  <= idx_t'(NREQ - 1);
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      dur_q   <= dur_d;
    end
  end

  // Counter is held at zero in IDLE and cleared on the edge that leaves RUN,
  // so it reads 0 in DONE and starts from 0 on the first RUN cycle.
  assign cnt_en  = (state_q == S_RUN);
  assign cnt_clr = (state_q == S_IDLE) || ((state_q == S_RUN) && (state_d != S_RUN));

  interval_counter #(.CW(CW)) u_counter (
    .clk   (clk),
    .rst_n (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (cnt)
  );

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.grant = (state_q == S_RUN)  ? win_oh : '0;
  assign bus.done  = (state_q == S_DONE) ? win_oh : '0;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.count = cnt;

endmodule

// File: tb/tb_interval_scheduler.sv
// Self-checking bench for interval_scheduler: directed scenarios with constant
// expectations plus randomized traffic compared against a window-level model.
module tb_interval_scheduler;
  import interval_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int OW   = 2*NREQ + 1 + CW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interval_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus();

  interval_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [OW-1:0] obs_vec;
  assign obs_vec = {bus.grant, bus.done, bus.busy, bus.count};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: who owns the counter, how long it has owned it, the
  // window length it was given, who is being told "done", and who won last.
  int m_owner, m_elapsed, m_len, m_done_who, m_last;

  task automatic model_reset();
    m_owner    = -1;
    m_elapsed  = 0;
    m_len      = 0;
    m_done_who = -1;
    m_last     = NREQ - 1;
  endtask

  task automatic model_edge();
    if (m_done_who >= 0) begin
      m_done_who = -1;
    end else if (m_owner >= 0) begin
      if (!bus.req[m_owner]) m_owner = -1;
      else if (m_elapsed == m_len - 1) begin
        m_done_who = m_owner;
        m_owner    = -1;
      end else m_elapsed++;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (bus.req[c]) begin
          m_last = c;
          m_len  = int'(bus.duration[c*CW +: CW]);
          if (m_len == 0) m_done_who = c;
          else begin
            m_owner   = c;
            m_elapsed = 0;
          end
          break;
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [NREQ-1:0] g, d;
    logic [CW-1:0]   c;
    logic            b;
    g = '0; d = '0; c = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      c          = CW'(m_elapsed);
    end
    if (m_done_who >= 0) d[m_done_who] = 1'b1;
    b = (m_owner >= 0) || (m_done_who >= 0);
    return {g, d, b, c};
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: the model sees the same inputs the DUT samples; outputs are
  // then observed at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.req = '0;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs against the model until every request is served; completed
  // requesters drop their request after done.
  task automatic run_with_model(input string name, input int max_cyc, output int max_count);
    bit idle_seen;
    idle_seen = 1'b0;
    max_count = 0;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, obs_vec, exp_vec());
      end
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      if (m_done_who >= 0) bus.req[m_done_who] = 1'b0;
      if (bus.req == '0 && m_owner < 0 && m_done_who < 0) begin
        idle_seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!idle_seen) begin
      n_errors++;
      $display("FAIL %s_timeout got=busy want=idle within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    bus.req      = '0;
    bus.duration = '0;
    reset        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL reset_hold got=%h want=0", obs_vec);
    end
    reset = 1'b1;
    repeat (2) begin
      step();
      n_checks++;
      if (obs_vec !== '0) begin
        n_errors++;
        $display("FAIL reset_idle got=%h want=0", obs_vec);
      end
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] want;
    bus.duration[0 +: CW] = CW'(5);
    bus.req               = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      want = {4'b0001, 4'b0000, 1'b1, CW'(k)};
      n_checks++;
      if (obs_vec !== want) begin
        n_errors++;
        $display("FAIL single_run k=%0d got=%h want=%h", k, obs_vec, want);
      end
    end
    step();
    want = {4'b0000, 4'b0001, 1'b1, CW'(0)};
    n_checks++;
    if (obs_vec !== want) begin
      n_errors++;
      $display("FAIL single_done got=%h want=%h", obs_vec, want);
    end
    bus.req = '0;
    step();
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL single_idle got=%h want=0", obs_vec);
    end
  endtask

  task automatic test_all_requesting();
    int gq[$], sq[$], dq[$];
    logic [NREQ-1:0] prev_g;
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.duration[i*CW +: CW] = CW'(3);
    bus.req = '1;
    prev_g  = '0;
    for (int n = 0; n < 40; n++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL all_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
      if (bus.grant != '0 && bus.grant != prev_g) begin
        gq.push_back(oh_idx(bus.grant));
        sq.push_back(cyc);
      end
      if (bus.done != '0) dq.push_back(oh_idx(bus.done));
      prev_g = bus.grant;
      if (m_done_who >= 0) bus.req[m_done_who] = 1'b0;
      if (bus.req == '0 && m_owner < 0 && m_done_who < 0) break;
    end
    n_checks++;
    if (gq.size() != 4 || dq.size() != 4) begin
      n_errors++;
      $display("FAIL all_count got grants=%0d dones=%0d want 4/4", gq.size(), dq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (gq[i] != i || dq[i] != i) begin
          n_errors++;
          $display("FAIL all_order slot=%0d got grant=%0d done=%0d want %0d", i, gq[i], dq[i], i);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (sq[i+1] - sq[i] != 5) begin
          n_errors++;
          $display("FAIL all_spacing slot=%0d got=%0d want=5", i, sq[i+1] - sq[i]);
        end
      end
    end
  endtask

  task automatic test_zero_duration();
    logic [OW-1:0] want;
    int mx;
    bus.duration[2*CW +: CW] = '0;
    bus.req                  = 4'b0100;
    step();
    want = {4'b0000, 4'b0100, 1'b1, CW'(0)};
    n_checks++;
    if (obs_vec !== want) begin
      n_errors++;
      $display("FAIL zero_done got=%h want=%h", obs_vec, want);
    end
    bus.req = '0;
    step();
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL zero_idle got=%h want=0", obs_vec);
    end
    bus.duration[1*CW +: CW] = CW'(2);
    bus.req                  = 4'b0010;
    run_with_model("zero_next", 20, mx);
    n_checks++;
    if (mx != 1) begin
      n_errors++;
      $display("FAIL zero_next_count got=%0d want=1", mx);
    end
  endtask

  task automatic test_cancel();
    logic [OW-1:0] want;
    bit reached;
    int mx;
    reached                  = 1'b0;
    bus.duration[1*CW +: CW] = CW'(10);
    bus.req                  = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL cancel_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
      if (m_owner == 1 && m_elapsed == 0) begin
        bus.req[3]               = 1'b1;
        bus.duration[3*CW +: CW] = CW'(4);
      end
      if (m_owner == 1 && m_elapsed == 2) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached) begin
      n_errors++;
      $display("FAIL cancel_reach got=no count 2 want=count 2 on requester 1");
    end
    bus.req[1] = 1'b0;
    step();
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL cancel_drop got=%h want=0", obs_vec);
    end
    step();
    want = {4'b1000, 4'b0000, 1'b1, CW'(0)};
    n_checks++;
    if (obs_vec !== want) begin
      n_errors++;
      $display("FAIL cancel_next got=%h want=%h", obs_vec, want);
    end
    run_with_model("cancel_drain", 20, mx);
  endtask

  task automatic test_reset_in_run();
    logic [OW-1:0] want;
    int mx;
    bus.duration[0 +: CW] = CW'(20);
    bus.req               = 4'b0001;
    repeat (4) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL rst_run_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL rst_async got=%h want=0", obs_vec);
    end
    model_reset();
    bus.req                  = 4'b0011;
    bus.duration[0 +: CW]    = CW'(2);
    bus.duration[1*CW +: CW] = CW'(2);
    @(negedge clk);
    reset = 1'b1;
    step();
    want = {4'b0001, 4'b0000, 1'b1, CW'(0)};
    n_checks++;
    if (obs_vec !== want) begin
      n_errors++;
      $display("FAIL rst_first_winner got=%h want=%h", obs_vec, want);
    end
    run_with_model("rst_drain", 20, mx);
  endtask

  task automatic test_fairness();
    int gq[$];
    logic [NREQ-1:0] prev_g;
    int mx;
    do_reset();
    bus.duration[0 +: CW]    = CW'(2);
    bus.duration[3*CW +: CW] = CW'(2);
    bus.req                  = 4'b1001;
    prev_g                   = '0;
    for (int n = 0; n < 14; n++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL fair_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
      if (bus.grant != '0 && bus.grant != prev_g) gq.push_back(oh_idx(bus.grant));
      prev_g = bus.grant;
      if (m_done_who == 3) bus.req[3] = 1'b0;
    end
    n_checks++;
    if (gq.size() < 3) begin
      n_errors++;
      $display("FAIL fair_count got=%0d want>=3", gq.size());
    end else if (gq[0] != 0 || gq[1] != 3 || gq[2] != 0) begin
      n_errors++;
      $display("FAIL fair_order got=%0d,%0d,%0d want=0,3,0", gq[0], gq[1], gq[2]);
    end
    bus.req = '0;
    run_with_model("fair_drain", 20, mx);
  endtask

  task automatic test_max_window();
    int mx;
    bus.duration[2*CW +: CW] = '1;
    bus.req                  = 4'b0100;
    run_with_model("max_window", 300, mx);
    n_checks++;
    if (mx != (1 << CW) - 2) begin
      n_errors++;
      $display("FAIL max_count got=%0d want=%0d", mx, (1 << CW) - 2);
    end
  endtask

  task automatic test_random();
    int mx;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_done_who == i) bus.req[i] = 1'b0;
        else if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) begin
            bus.req[i]               = 1'b1;
            bus.duration[i*CW +: CW] = CW'($urandom_range(7));
          end
        end else if ($urandom_range(19) == 0) bus.req[i] = 1'b0;
        // Late duration writes must not disturb a latched window.
        if ($urandom_range(7) == 0) bus.duration[i*CW +: CW] = CW'($urandom_range(7));
      end
      step();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
    run_with_model("random_drain", 60, mx);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_zero_duration();
    test_cancel();
    test_reset_in_run();
    test_fairness();
    test_max_window();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
